ahb_mem_ctrl: RTL and testbench

- AHB-Lite slave controller that sequences the single-port synchronous SRAM (`mem`, 1-cycle registered read, per-byte write enables) onto the system bus.
- Decodes address phases, generates SRAM address, write-enable, byte-enable and write data, and inserts wait states for read latency.
- Issues two-cycle ERROR responses for unsupported transfers.
- Sits between the AHB interconnect (slave port) and one `mem` instance.

---
 rtl/ahb_mem_ctrl.sv | 104 ++++++++++
 tb/tb_ahb_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_ctrl.sv
// AHB-Lite slave front end for a single-port synchronous SRAM with a 1-cycle
// registered read. Writes complete with zero wait states and reads with one.
// Misaligned or oversized transfers get a two-cycle ERROR response and never
// reach the SRAM.
module ahb_mem_ctrl #(
    parameter int ABITS = 10,
    parameter int DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hsel_i,
    input  logic [31:0]      haddr_i,
    input  logic [1:0]       htrans_i,
    input  logic             hwrite_i,
    input  logic [2:0]       hsize_i,
    input  logic [DBITS-1:0] hwdata_i,
    input  logic             hready_i,
    output logic             hreadyout_o,
    output logic             hresp_o,
    output logic [DBITS-1:0] hrdata_o,
    output logic [ABITS-1:0] mem_addr_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [DBITS-1:0] mem_din_o,
    input  logic [DBITS-1:0] mem_dout_i
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_DATA,
        ERR1,
        ERR2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic       accept;
    logic       illegal;
    logic [3:0] be_dec;

    // Upper address bits alias and htrans[0] (SEQ vs NONSEQ) does not matter here.
    logic unused_bits;
    assign unused_bits = ^{haddr_i[31:ABITS+2], htrans_i[0]};

    // Address-phase decode: acceptance, legality, byte lanes and next state.
    always_comb begin
        accept  = hsel_i & htrans_i[1] & hready_i;
        illegal = (hsize_i > 3'd2)
               || ((hsize_i == 3'd1) && haddr_i[0])
               || ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00));

        case (hsize_i)
            3'd0:    be_dec = 4'b0001 << haddr_i[1:0];
            3'd1:    be_dec = haddr_i[1] ? 4'b1100 : 4'b0011;
            default: be_dec = 4'b1111;
        endcase

        state_n = IDLE;
        case (state)
            RD_WAIT: state_n = RD_DATA;
            ERR1:    state_n = ERR2;
            default: begin
                // IDLE, WRITE, RD_DATA and ERR2 all accept a new address phase.
                if (accept) begin
                    if (illegal)       state_n = ERR1;
                    else if (hwrite_i) state_n = WRITE;
                    else               state_n = RD_WAIT;
                end
            end
        endcase
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            hreadyout_o <= 1'b1;
            hresp_o     <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= '0;
        end else begin
            state       <= state_n;
            hreadyout_o <= (state_n != RD_WAIT) && (state_n != ERR1);
            hresp_o     <= (state_n == ERR1) || (state_n == ERR2);
            mem_we_o    <= (state_n == WRITE);
            mem_be_o    <= (state_n == WRITE) ? be_dec : 4'b0000;
            // WRITE and RD_WAIT are only entered from an accepted legal transfer.
            if ((state_n == WRITE) || (state_n == RD_WAIT)) begin
                mem_addr_o <= haddr_i[ABITS+1:2];
            end
        end
    end

    // Write data passes straight through in the data phase; the SRAM latches it
    // at the edge that ends WRITE.
    assign mem_din_o = (state == WRITE) ? hwdata_i : '0;

    // Read data is the SRAM's registered output, shown only in the completing cycle.
    assign hrdata_o  = (state == RD_DATA) ? mem_dout_i : '0;

endmodule

// File: tb/tb_ahb_mem_ctrl.sv
// Scoreboard bench for ahb_mem_ctrl: an AHB master driver pushes expected
// responses and SRAM writes into queues, and a monitor pops and compares them
// as the slave completes each data phase.
module tb_ahb_mem_ctrl;

    localparam int ABITS = 10;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [1:0]  htrans_i;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [31:0] hwdata_i;
    logic        hready_i;
    logic        hreadyout_o;
    logic        hresp_o;
    logic [31:0] hrdata_o;
    logic [ABITS-1:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_din_o;
    logic [31:0] mem_dout_i;

    always #5 clk = ~clk;

    assign hready_i = hreadyout_o;

    ahb_mem_ctrl #(.ABITS(ABITS), .DBITS(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .hsel_i(hsel_i), .haddr_i(haddr_i),
        .htrans_i(htrans_i), .hwrite_i(hwrite_i), .hsize_i(hsize_i),
        .hwdata_i(hwdata_i), .hready_i(hready_i), .hreadyout_o(hreadyout_o),
        .hresp_o(hresp_o), .hrdata_o(hrdata_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_din_o(mem_din_o),
        .mem_dout_i(mem_dout_i)
    );

    // SRAM model: byte-masked write and registered read.
    logic [31:0] sram [0:(1<<ABITS)-1];
    always @(posedge clk) begin
        if (mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_din_o[8*b +: 8];
            end
        end
        mem_dout_i <= sram[mem_addr_o];
    end

    typedef struct {
        bit          write;
        bit          resp;
        int          waits;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic [ABITS-1:0] addr;
        logic [3:0]       be;
        logic [31:0]      din;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: track the master's data phase and compare on completion.
    bit   dph = 1'b0;
    int   waits = 0;
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        bit   rd_done;
        rd_done = 1'b0;
        if (!rst_ni) begin
            dph = 1'b0;
        end else begin
            if (dph) begin
                if (hreadyout_o) begin
                    if (rq.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        e = rq.pop_front();
                        check("hresp", {31'd0, hresp_o}, {31'd0, e.resp});
                        check("wait_states", waits, e.waits);
                        if (!e.write && !e.resp) begin
                            check("hrdata", hrdata_o, e.rdata);
                            rd_done = 1'b1;
                        end
                    end
                end else begin
                    waits++;
                    if (rq.size() != 0) check("hresp_wait", {31'd0, hresp_o}, {31'd0, rq[0].resp});
                end
            end
            if (!rd_done) check("hrdata_zero", hrdata_o, 32'h0);
            if (mem_we_o) begin
                if (wq.size() == 0) begin
                    fail_now("sram_write_unexpected");
                end else begin
                    w = wq.pop_front();
                    check("mem_addr", {22'd0, mem_addr_o}, {22'd0, w.addr});
                    check("mem_be", {28'd0, mem_be_o}, {28'd0, w.be});
                    check("mem_din", mem_din_o, w.din);
                end
            end
            if (hsel_i && htrans_i[1] && hready_i) begin
                dph   = 1'b1;
                waits = 0;
            end else if (dph && hreadyout_o) begin
                dph = 1'b0;
            end
        end
    end

    // Driver
    logic [31:0] pend_wdata = 32'h0;

    task automatic wait_ready();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (hreadyout_o) break;
            n++;
            if (n > 20) begin
                fail_now("hready_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        hsel_i   = 1'b1;
        htrans_i = 2'b10;
        hwrite_i = w;
        haddr_i  = a;
        hsize_i  = s;
        hwdata_i = pend_wdata;
        wait_ready();
        pend_wdata = wd;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                      input logic [ABITS-1:0] word, input logic [3:0] be);
        rsp_t r;
        wr_t  w;
        r = '{write: 1'b1, resp: 1'b0, waits: 0, rdata: 32'h0};
        w = '{addr: word, be: be, din: wd};
        rq.push_back(r);
        wq.push_back(w);
        issue(1'b1, a, s, wd);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] s, input logic [31:0] exp);
        rsp_t r;
        r = '{write: 1'b0, resp: 1'b0, waits: 1, rdata: exp};
        rq.push_back(r);
        issue(1'b0, a, s, 32'h0);
    endtask

    task automatic bad(input bit w, input logic [31:0] a, input logic [2:0] s);
        rsp_t r;
        r = '{write: w, resp: 1'b1, waits: 1, rdata: 32'h0};
        rq.push_back(r);
        issue(w, a, s, 32'hFFFF_FFFF);
    endtask

    task automatic drive_idle();
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        hwdata_i = pend_wdata;
    endtask

    task automatic idle();
        drive_idle();
        wait_ready();
        pend_wdata = 32'h0;
        hwdata_i   = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout"}, {31'd0, hreadyout_o}, 32'd1);
        check({tag, "_hresp"}, {31'd0, hresp_o}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we_o}, 32'd0);
    endtask

    initial begin
        // Reset held with a NONSEQ write presented.
        rst_ni   = 1'b0;
        hsel_i   = 1'b1;
        htrans_i = 2'b10;
        hwrite_i = 1'b1;
        haddr_i  = 32'h10;
        hsize_i  = 3'd2;
        hwdata_i = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        check("reset_hrdata", hrdata_o, 32'h0);
        drive_idle();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Word write then back-to-back read.
        wr(32'h10, 3'd2, 32'hDEAD_BEEF, 10'd4, 4'b1111);
        rd(32'h10, 3'd2, 32'hDEAD_BEEF);
        idle();

        // Byte writes on each lane, then word read.
        wr(32'h20, 3'd0, 32'h0000_0011, 10'd8, 4'b0001);
        wr(32'h21, 3'd0, 32'h0000_2200, 10'd8, 4'b0010);
        wr(32'h22, 3'd0, 32'h0033_0000, 10'd8, 4'b0100);
        wr(32'h23, 3'd0, 32'h4400_0000, 10'd8, 4'b1000);
        rd(32'h20, 3'd2, 32'h4433_2211);
        idle();

        // Upper half-word over a cleared word.
        wr(32'h20, 3'd2, 32'h0000_0000, 10'd8, 4'b1111);
        wr(32'h22, 3'd1, 32'hABCD_0000, 10'd8, 4'b1100);
        rd(32'h20, 3'd2, 32'hABCD_0000);
        idle();

        // Illegal transfers, then a legal read (also through an aliased address).
        bad(1'b0, 32'h21, 3'd2);
        bad(1'b1, 32'h23, 3'd1);
        bad(1'b0, 32'h20, 3'd3);
        rd(32'h20, 3'd2, 32'hABCD_0000);
        rd(32'h0000_1020, 3'd2, 32'hABCD_0000);
        idle();

        // Reset during RD_WAIT abandons the read.
        wr(32'h40, 3'd2, 32'h0BAD_F00D, 10'd16, 4'b1111);
        issue(1'b0, 32'h40, 3'd2, 32'h0);
        drive_idle();
        #1 rst_ni = 1'b0;
        #1 check_reset_outputs("rst_rdwait");
        check("rst_rdwait_hrdata", hrdata_o, 32'h0);
        pend_wdata = 32'h0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Reset during the WRITE data phase drops the write.
        issue(1'b1, 32'h40, 3'd2, 32'h5555_5555);
        drive_idle();
        #1 rst_ni = 1'b0;
        #1 check_reset_outputs("rst_write");
        pend_wdata = 32'h0;
        hwdata_i   = 32'h0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        rd(32'h40, 3'd2, 32'h0BAD_F00D);
        idle();

        repeat (3) @(posedge clk);
        check("rsp_queue_drained", rq.size(), 32'd0);
        check("wr_queue_drained", wq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
